// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-refill side (I)
// and a data side (D). A granted side owns the memory port until the memory
// signals completion; every transaction is followed by one WAIT cycle so the
// finished requester can drop its request before arbitration runs again.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the winner of
// simultaneous requests (a 1-bit last-grant register remembers the previous
// winner). Left undefined, the D side always wins a tie.
//
// Handshake: a requester raises i_IReq/i_DReq and holds it (with address and
// data stable) until its ready output pulses for exactly one cycle. Read data
// on o_IData/o_DData is only meaningful in that ready cycle. On the memory
// side, o_MemReq stays high with stable address/data until i_MemReady is seen
// high for one cycle; i_MemReady outside a grant is ignored.
module mem_arbiter #(
    parameter int BLOCK_SIZE = 1,
    parameter int XLEN       = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    // Instruction-cache refill side
    input  logic                     i_IReq,
    input  logic [XLEN-1:0]          i_IAddr,
    output logic [BLOCK_SIZE*32-1:0] o_IData,
    output logic                     o_IReady,
    // Data side
    input  logic                     i_DReq,
    input  logic                     i_DWe,
    input  logic [XLEN-1:0]          i_DAddr,
    input  logic [31:0]              i_DWData,
    output logic [31:0]              o_DData,
    output logic                     o_DReady,
    // Memory side
    output logic                     o_MemReq,
    output logic                     o_MemWe,
    output logic [XLEN-1:0]          o_MemAddr,
    output logic [31:0]              o_MemWData,
    input  logic [BLOCK_SIZE*32-1:0] i_MemRData,
    input  logic                     i_MemReady,
    // Current FSM state, for observation only
    output logic [1:0]               o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        WAIT    = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Winner of the arbitration in the current cycle (1 = D side).
    logic pick_d;

    // Low address bits of the instruction address are dropped on purpose:
    // refills are always word aligned.
    logic unused_iaddr_bits;
    assign unused_iaddr_bits = ^i_IAddr[1:0];

`ifdef ARB_ROUND_ROBIN_EN
    // Side granted most recently: 0 = I, 1 = D.
    logic last_grant_q;
    logic last_grant_d;

    // Arbitration: a tie goes to the side that did not win last time.
    always_comb begin
        pick_d = 1'b0;
        if (i_DReq && !i_IReq) begin
            pick_d = 1'b1;
        end else if (i_DReq && i_IReq) begin
            pick_d = (last_grant_q == 1'b0);
        end
    end

    // Remember the winner whenever a new grant is issued from IDLE.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (i_IReq || i_DReq)) begin
            last_grant_d = pick_d;
        end
    end

    // Last-grant register; reset points at I so the first tie goes to D.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Arbitration: fixed priority, D side wins every tie.
    always_comb begin
        pick_d = 1'b0;
        if (i_DReq) begin
            pick_d = 1'b1;
        end
    end
`endif

    // Next-state logic: grant from IDLE, hold the grant until the memory
    // completes, then spend one cycle in WAIT before arbitrating again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_IReq || i_DReq) begin
                    state_d = pick_d ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (i_MemReady) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output routing: the memory port mirrors the granted requester and is
    // all-zero otherwise; ready pulses only while granted and memory completes.
    always_comb begin
        o_MemReq   = 1'b0;
        o_MemWe    = 1'b0;
        o_MemAddr  = '0;
        o_MemWData = '0;
        o_IReady   = 1'b0;
        o_DReady   = 1'b0;
        case (state_q)
            GRANT_I: begin
                o_MemReq  = 1'b1;
                o_MemAddr = {i_IAddr[XLEN-1:2], 2'b00};
                o_IReady  = i_MemReady;
            end
            GRANT_D: begin
                o_MemReq   = 1'b1;
                o_MemWe    = i_DWe;
                o_MemAddr  = i_DAddr;
                o_MemWData = i_DWData;
                o_DReady   = i_MemReady;
            end
            default: begin
            end
        endcase
    end

    // Read data passes straight through; requesters sample it on ready.
    assign o_IData     = i_MemRData;
    assign o_DData     = i_MemRData[31:0];
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter. Stimulus pushes
// each expected memory transaction; a negedge monitor compares the memory
// port against the queue head while granted and pops on completion.
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int BS   = 1;
    // Expected entry layout: {side(1=D), we, addr[31:0], wdata[31:0], rdata[31:0]}
    localparam int EW   = 98;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd3;

    logic            clk = 1'b0;
    logic            i_rst;
    logic            i_IReq;
    logic [XLEN-1:0] i_IAddr;
    logic [BS*32-1:0] o_IData;
    logic            o_IReady;
    logic            i_DReq;
    logic            i_DWe;
    logic [XLEN-1:0] i_DAddr;
    logic [31:0]     i_DWData;
    logic [31:0]     o_DData;
    logic            o_DReady;
    logic            o_MemReq;
    logic            o_MemWe;
    logic [XLEN-1:0] o_MemAddr;
    logic [31:0]     o_MemWData;
    logic [BS*32-1:0] i_MemRData;
    logic            i_MemReady;
    logic [1:0]      o_dbg_state;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int checks = 0;
    int errors = 0;

    mem_arbiter #(.BLOCK_SIZE(BS), .XLEN(XLEN)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_IReq     (i_IReq),
        .i_IAddr    (i_IAddr),
        .o_IData    (o_IData),
        .o_IReady   (o_IReady),
        .i_DReq     (i_DReq),
        .i_DWe      (i_DWe),
        .i_DAddr    (i_DAddr),
        .i_DWData   (i_DWData),
        .o_DData    (o_DData),
        .o_DReady   (o_DReady),
        .o_MemReq   (o_MemReq),
        .o_MemWe    (o_MemWe),
        .o_MemAddr  (o_MemAddr),
        .o_MemWData (o_MemWData),
        .i_MemRData (i_MemRData),
        .i_MemReady (i_MemReady),
        .o_dbg_state(o_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] mk(input logic side, input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [31:0] rdata);
        return {side, we, addr, wdata, rdata};
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (i_rst === 1'b1) begin
            if (o_MemReq === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant actual=addr %0h required=no request", o_MemAddr);
                end else begin
                    mon_e = exp_q[0];
                    check("mem_we", o_MemWe, mon_e[96]);
                    check("mem_addr", o_MemAddr, mon_e[95:64]);
                    check("mem_wdata", o_MemWData, mon_e[63:32]);
                    if (i_MemReady === 1'b1) begin
                        check("i_ready", o_IReady, !mon_e[97]);
                        check("d_ready", o_DReady, mon_e[97]);
                        if (mon_e[97]) check("d_data", o_DData, mon_e[31:0]);
                        else           check("i_data", o_IData, mon_e[31:0]);
                        void'(exp_q.pop_front());
                    end else begin
                        check("ready_before_mem", {o_IReady, o_DReady}, 2'b00);
                    end
                end
            end else begin
                check("idle_outputs", {o_MemWe, o_MemAddr, o_MemWData, o_IReady, o_DReady}, '0);
            end
        end
    end

    // Memory responder: wait for a grant, hold it lat (>=1) cycles, then
    // complete with one-cycle i_MemReady. Returns in the WAIT cycle.
    task automatic mem_respond(input int lat, input logic [31:0] rd, output int waited);
        int n = 0;
        @(negedge clk);
        while (o_MemReq !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout actual=no o_MemReq required=o_MemReq within 20 cycles");
            return;
        end
        repeat (lat) tick();
        i_MemReady = 1'b1;
        i_MemRData = rd;
        tick();
        i_MemReady = 1'b0;
        i_MemRData = '0;
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        i_IReq = 1'b0; i_IAddr = '0;
        i_DReq = 1'b0; i_DWe = 1'b0; i_DAddr = '0; i_DWData = '0;
        i_MemReady = 1'b0; i_MemRData = '0;
        repeat (2) tick();
        @(negedge clk);
        check("reset_state", o_dbg_state, ST_IDLE);
        check("reset_outputs", {o_MemReq, o_MemWe, o_MemAddr, o_MemWData, o_IReady, o_DReady}, '0);
        tick();
        i_rst = 1'b1;
    endtask

    task automatic check_wait();
        @(negedge clk);
        check("wait_state", o_dbg_state, ST_WAIT);
        check("wait_no_req", o_MemReq, 1'b0);
        tick();
    endtask

    // Main stimulus
    initial begin
        int w;
        do_reset();

        // Instruction refill, unaligned address, completion two cycles after request
        i_IReq = 1'b1; i_IAddr = 32'h0000_1003;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h1111_2222));
        @(negedge clk);
        check("no_req_same_cycle", o_MemReq, 1'b0);
        mem_respond(1, 32'h1111_2222, w);
        check("req_latency", w, 0);
        i_IReq = 1'b0;
        check_wait();

        // Data write held for several cycles before memory completes
        i_DReq = 1'b1; i_DWe = 1'b1; i_DAddr = 32'h0000_2000; i_DWData = 32'hDEAD_BEEF;
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0));
        mem_respond(3, 32'h0, w);
        i_DReq = 1'b0; i_DWe = 1'b0;
        check_wait();

        // Data read, read data returned on o_DData
        i_DReq = 1'b1; i_DWe = 1'b0; i_DAddr = 32'h0000_2004; i_DWData = 32'h1234_5678;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_2004, 32'h1234_5678, 32'hCAFE_F00D));
        mem_respond(1, 32'hCAFE_F00D, w);
        i_DReq = 1'b0;
        check_wait();

        // Stray i_MemReady with nothing pending
        i_MemReady = 1'b1; i_MemRData = 32'h7777_7777;
        repeat (3) begin
            @(negedge clk);
            check("stray_ready_state", o_dbg_state, ST_IDLE);
            check("stray_ready_out", {o_IReady, o_DReady}, 2'b00);
            tick();
        end
        i_MemReady = 1'b0; i_MemRData = '0;

        // Both sides requesting continuously from a fresh reset
        do_reset();
        i_IReq = 1'b1; i_IAddr = 32'h0000_3006;
        i_DReq = 1'b1; i_DWe = 1'b0; i_DAddr = 32'h0000_4000; i_DWData = 32'h0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (i % 2 == 0) exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_4000, 32'h0, 32'hA000_0000 + i));
            else            exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_3004, 32'h0, 32'hA000_0000 + i));
`else
            exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_4000, 32'h0, 32'hA000_0000 + i));
`endif
        end
        for (int i = 0; i < 4; i++) begin
            mem_respond(1, 32'hA000_0000 + i, w);
        end
        i_IReq = 1'b0; i_DReq = 1'b0;
        check_wait();

        // Reset in the second cycle of a data grant, late i_MemReady ignored
        i_DReq = 1'b1; i_DWe = 1'b1; i_DAddr = 32'h0000_5000; i_DWData = 32'h55AA_55AA;
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_5000, 32'h55AA_55AA, 32'h0));
        @(negedge clk);
        w = 0;
        while (o_MemReq !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("abort_grant_seen", o_MemReq, 1'b1);
        tick();
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1; i_DReq = 1'b0; i_DWe = 1'b0;
        exp_q.delete();
        i_MemReady = 1'b1; i_MemRData = 32'h9999_9999;
        @(negedge clk);
        check("abort_state", o_dbg_state, ST_IDLE);
        check("abort_d_ready", o_DReady, 1'b0);
        check("abort_mem_out", {o_MemReq, o_MemWe, o_MemAddr, o_MemWData}, '0);
        tick();
        i_MemReady = 1'b0; i_MemRData = '0;
        @(negedge clk);
        check("abort_state_after", o_dbg_state, ST_IDLE);
        tick();

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
